// File: rtl/harvard_wb_pkg.sv
// Shared types and helpers for the Harvard-core to dual-Wishbone bridge.
package harvard_wb_pkg;

    typedef enum logic [1:0] {IDLE, BUS, RESP} ch_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Number of address LSBs covered by one data word.
    function automatic int unsigned sel_lsb_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/harvard_wb_bridge_if.sv
// Core-side request/response ports and both Wishbone master sets of the bridge.
// master: the bridge's view; slave: the core/Wishbone environment's view.
interface harvard_wb_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [SEL_W-1:0]  d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_err;

    logic              stall_o;

    logic              core_cyc, core_stb, core_we;
    logic [SEL_W-1:0]  core_sel;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_data_out;
    logic [DATA_W-1:0] core_data_in;
    logic              core_ack;

    logic              data_mem_cyc, data_mem_stb, data_mem_we;
    logic [SEL_W-1:0]  data_mem_sel;
    logic [ADDR_W-1:0] data_mem_addr;
    logic [DATA_W-1:0] data_mem_data_out;
    logic [DATA_W-1:0] data_mem_data_in;
    logic              data_mem_ack;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  core_data_in, core_ack, data_mem_data_in, data_mem_ack,
        output if_rdata, if_rvalid, if_err, d_rdata, d_rvalid, d_err, stall_o,
        output core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
        output data_mem_cyc, data_mem_stb, data_mem_we, data_mem_sel, data_mem_addr,
        output data_mem_data_out
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output core_data_in, core_ack, data_mem_data_in, data_mem_ack,
        input  if_rdata, if_rvalid, if_err, d_rdata, d_rvalid, d_err, stall_o,
        input  core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
        input  data_mem_cyc, data_mem_stb, data_mem_we, data_mem_sel, data_mem_addr,
        input  data_mem_data_out
    );

endinterface

// File: rtl/wb_channel.sv
// One Wishbone request channel: IDLE/BUS/RESP FSM, request latch and bus timeout.
// WB_PIPELINED_EN: single-cycle stb and registered ack/data; otherwise classic stb=cyc.
module wb_channel
    import harvard_wb_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_sel,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err,
    output logic                  pending,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [DATA_W/8-1:0]   wb_sel,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_data_out,
    input  logic [DATA_W-1:0]     wb_data_in,
    input  logic                  wb_ack
);
    localparam int unsigned       SEL_W     = DATA_W / 8;
    localparam int unsigned       LSB       = sel_lsb_bits(DATA_W);
    localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << LSB) - 1);

    ch_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              ack_eff;
    logic [DATA_W-1:0] dat_eff;

`ifdef WB_PIPELINED_EN
    logic              ack_q;
    logic [DATA_W-1:0] dat_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wb_ack;
            dat_q <= wb_data_in;
        end
    end

    assign ack_eff = ack_q;
    assign dat_eff = dat_q;
    // The counter is still zero only in the first BUS cycle.
    assign wb_stb  = (state_q == BUS) && (tmo_q == '0);
`else
    assign ack_eff = wb_ack;
    assign dat_eff = wb_data_in;
    assign wb_stb  = (state_q == BUS);
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUS;
                    addr_d  = req_addr & ADDR_MASK;
                    we_d    = req_we;
                    sel_d   = req_sel;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            BUS: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (ack_eff) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : dat_eff;
                    err_d   = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RESP;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wb_cyc      = (state_q == BUS);
    assign wb_we       = we_q;
    assign wb_sel      = sel_q;
    assign wb_addr     = addr_q;
    assign wb_data_out = wdata_q;
    assign rvalid      = (state_q == RESP);
    assign err         = rvalid & err_q;
    assign rdata       = rdata_q;
    // Gated by rst_n so the core is not frozen while the bridge is held in reset.
    assign pending     = (state_q == BUS) || ((state_q == IDLE) && req && rst_n);

endmodule

// File: rtl/harvard_wb_bridge.sv
// Harvard core to dual Wishbone master bridge: fetch -> core_*, load/store -> data_mem_*.
// Optional WB_PIPELINED_EN selects Wishbone pipelined mode in both channels.
module harvard_wb_bridge
    import harvard_wb_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    harvard_wb_bridge_if.master  bus
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic pend_if, pend_d;

    wb_channel #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_DATA       (ERR_DATA)
    ) u_fetch (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req         (bus.if_req),
        .req_addr    (bus.if_addr),
        .req_we      (1'b0),
        .req_sel     ({SEL_W{1'b1}}),
        .req_wdata   ({DATA_W{1'b0}}),
        .rdata       (bus.if_rdata),
        .rvalid      (bus.if_rvalid),
        .err         (bus.if_err),
        .pending     (pend_if),
        .wb_cyc      (bus.core_cyc),
        .wb_stb      (bus.core_stb),
        .wb_we       (bus.core_we),
        .wb_sel      (bus.core_sel),
        .wb_addr     (bus.core_addr),
        .wb_data_out (bus.core_data_out),
        .wb_data_in  (bus.core_data_in),
        .wb_ack      (bus.core_ack)
    );

    wb_channel #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_DATA       (ERR_DATA)
    ) u_data (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req         (bus.d_req),
        .req_addr    (bus.d_addr),
        .req_we      (bus.d_we),
        .req_sel     (bus.d_be),
        .req_wdata   (bus.d_wdata),
        .rdata       (bus.d_rdata),
        .rvalid      (bus.d_rvalid),
        .err         (bus.d_err),
        .pending     (pend_d),
        .wb_cyc      (bus.data_mem_cyc),
        .wb_stb      (bus.data_mem_stb),
        .wb_we       (bus.data_mem_we),
        .wb_sel      (bus.data_mem_sel),
        .wb_addr     (bus.data_mem_addr),
        .wb_data_out (bus.data_mem_data_out),
        .wb_data_in  (bus.data_mem_data_in),
        .wb_ack      (bus.data_mem_ack)
    );

    assign bus.stall_o = pend_if | pend_d;

endmodule

// File: tb/tb_harvard_wb_bridge.sv
// Self-checking bench for harvard_wb_bridge: directed scenarios plus random transaction pairs
// against a cycle-count reference model of the channel protocol.
module tb_harvard_wb_bridge;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int          TMO    = 8;
`ifdef WB_PIPELINED_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    harvard_wb_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    harvard_wb_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle (counted from the request cycle 0) in which rvalid is expected. Ack is driven in
    // cycle w+1; it becomes effective PIPE cycles later; BUS occupies cycles 1..TMO at most.
    function automatic int resp_of(input int w, output bit to);
        int k;
        k = w + 1 + PIPE;
        if (k <= TMO) begin
            to = 1'b0;
            return k + 1;
        end
        to = 1'b1;
        return TMO + 1;
    endfunction

    task automatic run_pair(input string name,
                            input bit en_if, input logic [31:0] a_if, input int w_if,
                            input logic [31:0] dat_if,
                            input bit en_d, input bit we, input logic [3:0] be,
                            input logic [31:0] a_d, input logic [31:0] wd, input int w_d,
                            input logic [31:0] dat_d);
        bit to_if, to_d, bus_if, bus_d;
        int r_if, r_d, last;
        r_if = resp_of(w_if, to_if);
        r_d  = resp_of(w_d, to_d);
        last = 1;
        if (en_if && r_if + 1 > last) last = r_if + 1;
        if (en_if && w_if + 2 + PIPE > last) last = w_if + 2 + PIPE;
        if (en_d && r_d + 1 > last) last = r_d + 1;
        if (en_d && w_d + 2 + PIPE > last) last = w_d + 2 + PIPE;
        for (int c = 0; c <= last; c++) begin
            @(posedge sys_clk);
            #1;
            if (c == 0) begin
                bus.if_req  = en_if;
                bus.if_addr = a_if;
                bus.d_req   = en_d;
                bus.d_we    = we;
                bus.d_be    = be;
                bus.d_addr  = a_d;
                bus.d_wdata = wd;
            end else begin
                // Request fields wander after acceptance; the latched copy must be used.
                bus.if_addr = $urandom;
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_be    = 4'($urandom);
                bus.d_we    = 1'($urandom);
            end
            bus.core_ack         = en_if && (c == w_if + 1);
            bus.core_data_in     = bus.core_ack ? dat_if : $urandom;
            bus.data_mem_ack     = en_d && (c == w_d + 1);
            bus.data_mem_data_in = bus.data_mem_ack ? dat_d : $urandom;
            @(negedge sys_clk);
            bus_if = en_if && (c >= 1) && (c < r_if);
            bus_d  = en_d && (c >= 1) && (c < r_d);
            chk({name, ":stall"}, bus.stall_o, (en_if && c < r_if) || (en_d && c < r_d));
            chk({name, ":if_cyc"}, bus.core_cyc, bus_if);
            chk({name, ":if_stb"}, bus.core_stb, PIPE ? (en_if && c == 1) : bus_if);
            chk({name, ":if_rvalid"}, bus.if_rvalid, en_if && c == r_if);
            chk({name, ":if_err"}, bus.if_err, en_if && c == r_if && to_if);
            chk({name, ":d_cyc"}, bus.data_mem_cyc, bus_d);
            chk({name, ":d_stb"}, bus.data_mem_stb, PIPE ? (en_d && c == 1) : bus_d);
            chk({name, ":d_rvalid"}, bus.d_rvalid, en_d && c == r_d);
            chk({name, ":d_err"}, bus.d_err, en_d && c == r_d && to_d);
            if (bus_if) begin
                chk({name, ":if_addr"}, bus.core_addr, a_if & ~32'h3);
                chk({name, ":if_sel"}, bus.core_sel, 4'hF);
                chk({name, ":if_we"}, bus.core_we, 1'b0);
                chk({name, ":if_dout"}, bus.core_data_out, 32'h0);
            end
            if (bus_d) begin
                chk({name, ":d_addr"}, bus.data_mem_addr, a_d & ~32'h3);
                chk({name, ":d_sel"}, bus.data_mem_sel, be);
                chk({name, ":d_we"}, bus.data_mem_we, we);
                chk({name, ":d_dout"}, bus.data_mem_data_out, wd);
            end
            if (en_if && c == r_if) begin
                chk({name, ":if_rdata"}, bus.if_rdata, to_if ? ERR_WORD : dat_if);
                bus.if_req = 1'b0;
            end
            if (en_d && c == r_d) begin
                chk({name, ":d_rdata"}, bus.d_rdata, to_d ? ERR_WORD : (we ? 32'h0 : dat_d));
                bus.d_req = 1'b0;
            end
        end
        @(posedge sys_clk);
        #1;
        bus.if_req       = 1'b0;
        bus.d_req        = 1'b0;
        bus.core_ack     = 1'b0;
        bus.data_mem_ack = 1'b0;
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.core_data_in = 0; bus.core_ack = 0;
        bus.data_mem_data_in = 0; bus.data_mem_ack = 0;

        #12;
        chk("rst:if_cyc", bus.core_cyc, 1'b0);
        chk("rst:if_stb", bus.core_stb, 1'b0);
        chk("rst:if_sel", bus.core_sel, 4'h0);
        chk("rst:if_addr", bus.core_addr, 32'h0);
        chk("rst:if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst:if_rdata", bus.if_rdata, 32'h0);
        chk("rst:d_cyc", bus.data_mem_cyc, 1'b0);
        chk("rst:d_we", bus.data_mem_we, 1'b0);
        chk("rst:d_dout", bus.data_mem_data_out, 32'h0);
        chk("rst:d_rvalid", bus.d_rvalid, 1'b0);
        chk("rst:d_err", bus.d_err, 1'b0);
        chk("rst:stall", bus.stall_o, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        run_pair("fetch", 1, 32'h1003, 0, 32'h13, 0, 0, 4'h0, 0, 0, 0, 0);
        run_pair("store", 0, 0, 0, 0, 1, 1, 4'b0011, 32'h2000, 32'hAABB_CCDD, 5, 32'h5555_1111);
        run_pair("tmo", 0, 0, 0, 0, 1, 0, 4'hF, 32'h4004, 0, 30, 32'h1234_5678);
        run_pair("conc", 1, 32'h0100, 0, 32'h0000_0093, 1, 0, 4'hF, 32'h3008, 0, 3, 32'hCAFE_F00D);
        run_pair("ackwin", 0, 0, 0, 0, 1, 0, 4'hF, 32'h5000, 0, TMO - 1 - PIPE, 32'h0BAD_CAFE);
        run_pair("be0", 0, 0, 0, 0, 1, 1, 4'h0, 32'h6002, 32'h7777_8888, 1, 0);
        run_pair("bothtmo", 1, 32'h7001, 12, 32'h1, 1, 0, 4'hC, 32'h7103, 0, 2, 32'h9999_0000);

        // Reset while the data channel is in BUS.
        @(posedge sys_clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h3000;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("rstbus:cyc_before", bus.data_mem_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstbus:cyc", bus.data_mem_cyc, 1'b0);
        chk("rstbus:stb", bus.data_mem_stb, 1'b0);
        chk("rstbus:stall", bus.stall_o, 1'b0);
        chk("rstbus:addr", bus.data_mem_addr, 32'h0);
        bus.d_req = 0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        bus.data_mem_ack = 1'b1;
        bus.data_mem_data_in = 32'h1234;
        for (int c = 0; c < 4; c++) begin
            @(negedge sys_clk);
            chk("rstbus:late_rvalid", bus.d_rvalid, 1'b0);
            chk("rstbus:late_cyc", bus.data_mem_cyc, 1'b0);
            chk("rstbus:late_stall", bus.stall_o, 1'b0);
            @(posedge sys_clk); #1;
            bus.data_mem_ack = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            bit en_if, en_d;
            en_if = 1'($urandom);
            en_d  = 1'($urandom);
            if (!en_if && !en_d) en_d = 1'b1;
            run_pair("rand", en_if, $urandom, int'($urandom_range(0, 10)), $urandom,
                     en_d, 1'($urandom), 4'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, 10)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/harvard_wb_bridge.md
Name: harvard_wb_bridge

Overview:
Parametrised successor to the single-CPU top-level glue. It adapts a Harvard-style core port pair to the two Wishbone master sets that `Controller` serves: instruction fetch drives `core_*`, load/store drives `data_mem_*`. Unlike the fixed 32-bit pass-through, it adds:
- a per-channel request FSM;
- core stall generation;
- byte-select generation;
- a bus timeout;
- a selectable data width.

Parameters:
- ADDR_W, 32, address width on both channels.
- DATA_W, 32, data width; legal values are 32 or 64. SEL_W = DATA_W/8.
- TIMEOUT_CYCLES, 1024, number of cycles in BUS without ack before the channel aborts; must be >= 2.
- ERR_DATA, 32'hDEAD_BEEF (zero-extended to DATA_W), read data returned on timeout.

Ports:
- sys_clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; the core holds it stable while stall_o=1.
- if_addr  in  ADDR_W  fetch address.
- if_rdata/if_rvalid/if_err  out  DATA_W/1/1  fetch response.
- d_req/d_we  in  1/1  data request and write flag.
- d_be  in  SEL_W  byte enables.
- d_addr/d_wdata  in  ADDR_W/DATA_W  data request fields.
- d_rdata/d_rvalid/d_err  out  DATA_W/1/1  data response.
- stall_o  out  1  core freeze.
- core_cyc/core_stb/core_we  out  1 each  fetch Wishbone control.
- core_sel/core_addr/core_data_out  out  SEL_W/ADDR_W/DATA_W  fetch Wishbone fields.
- core_data_in/core_ack  in  DATA_W/1  fetch Wishbone response.
- data_mem_cyc/data_mem_stb/data_mem_we  out  1 each  data Wishbone control.
- data_mem_sel/data_mem_addr/data_mem_data_out  out  SEL_W/ADDR_W/DATA_W  data Wishbone fields.
- data_mem_data_in/data_mem_ack  in  DATA_W/1  data Wishbone response.

Behaviour:
Reset:
- rst_n low: both FSMs go to IDLE immediately (asynchronous).
- Held at 0 while in reset: cyc, stb, we, sel, addr, data_out, rdata, rvalid, err, stall_o, timeout counters.
- Reset mid-transaction drops cyc/stb without waiting for ack; the bus is never left hung.

Channel FSM (identical per channel): states are IDLE, BUS, RESP.
- IDLE:
  - On req, latch addr (low log2(SEL_W) bits forced to 0), we, sel, wdata, then go to BUS.
  - Fetch channel latches we=0 and sel all-ones.
  - A data-channel write with be=0 is still issued (sel=0).
- BUS:
  - cyc=stb=1 from the registered state.
  - On effective ack: capture rdata (reads only; writes return 0), clear cyc/stb at the same edge, go to RESP.
  - Timeout counter increments each cycle in BUS. When it reaches TIMEOUT_CYCLES-1 with no ack: clear cyc/stb, rdata=ERR_DATA, set err, go to RESP.
- RESP: rvalid=1 for exactly one cycle (err too, if set), then go to IDLE.
- A new req seen in RESP is not accepted until IDLE (the next cycle).

Stall and handshake rules:
- Per-channel pending = (state==BUS) | (state==IDLE & req).
- stall_o = pending_if | pending_d (combinational).
- The core samples the response on rvalid.

Latency: req in cycle 0, stb in cycle 1, ack in cycle 1 → rvalid in cycle 2.

Boundary and corner cases:
- Ack while IDLE or RESP is ignored.
- req changes during BUS are ignored; the latched fields are used.
- Both channels are fully independent and may be outstanding simultaneously. Each channel's rvalid is independent.
- Ack in the same cycle as timeout: ack wins and err=0.

Optional Feature:
WB_PIPELINED_EN
- Defined:
  - Wishbone pipelined mode: stb is high only for the first BUS cycle; cyc stays high until ack.
  - ack and data_in are registered (reset to 0) before the FSM; effective ack arrives 1 cycle later, so the minimum latency is 3.
- Undefined:
  - Classic mode: stb equals cyc throughout BUS.
  - ack is used combinationally.

Decomposition:
- Package harvard_wb_pkg:
  - enum ch_state_e {IDLE, BUS, RESP};
  - ERR_DATA default;
  - function sel_lsb_bits(DATA_W).
- Sub-module wb_channel:
  - one FSM, latch, timeout counter and optional ack register;
  - instantiated twice, with the fetch instance tied to we=0 and sel all-ones.
- The top level holds only the instances and the stall_o OR.

Test Plan:
1. Fetch, classic mode: if_req=1, if_addr=0x1003, ack in cycle 1 with core_data_in=0x00000013 → core_addr=0x1000, sel=4'hF, if_rvalid in cycle 2 with 0x13; stall_o high in cycles 0–1.
2. Store: d_we=1, d_be=4'b0011, d_wdata=0xAABBCCDD, addr 0x2000, ack after 5 wait cycles → data_mem_we=1, sel=0011, d_rvalid once with d_rdata=0.
3. Timeout: TIMEOUT_CYCLES=8, data read with no ack → cyc drops after 8 BUS cycles, d_err=1, d_rdata=0xDEADBEEF.
4. Concurrent: fetch and load requested in the same cycle; acks at cycles 1 and 4 → if_rvalid at cycle 2, d_rvalid at cycle 5, stall_o low from cycle 5.
5. Reset mid-BUS: assert rst_n=0 in cycle 2 → cyc/stb=0 immediately (asynchronously); a late ack after reset release produces no rvalid.
6. WB_PIPELINED_EN defined: single read → stb high for 1 cycle only, rvalid one cycle later than in scenario 1.
